// File: rtl/ref_window_pkg.sv
// Shared definitions for the reference-window loader.
// - KERNEL_LEAD / KERNEL_EXT: the 8-tap HEVC luma filter needs 3 pixels
//   before and 4 after the block on each axis, so the window is N+7 wide.
// - state_t: loader FSM states.
// - win_edge(): window edge length for a given block edge.
// - clamp_max(): largest legal coordinate for a frame dimension.
package ref_window_pkg;

    localparam int KERNEL_LEAD = 3;
    localparam int KERNEL_EXT  = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int win_edge(input int num_pixel);
        return num_pixel + KERNEL_EXT;
    endfunction

    function automatic int clamp_max(input int frame_dim);
        return frame_dim - 1;
    endfunction

endpackage

// File: rtl/coord_clamp.sv
// Combinational coordinate generator for one axis.
// coord = clamp(base - LEAD + idx, 0, MAX_VAL)
// Ports:
//   base  : signed block origin, COORD_W+1 bits two's complement
//   idx   : unsigned offset into the window (column or row index)
//   coord : clamped frame coordinate, COORD_W bits unsigned
// The sum is formed at COORD_W+2 bits so the full signed base range plus
// the small window offset can never wrap before clamping.
module coord_clamp #(
    parameter int COORD_W = 12,
    parameter int IDX_W   = 4,
    parameter int LEAD    = 3,
    parameter int MAX_VAL = 1919
) (
    input  logic signed [COORD_W:0]   base,
    input  logic        [IDX_W-1:0]   idx,
    output logic        [COORD_W-1:0] coord
);

    localparam logic signed [COORD_W+1:0] LEAD_S = (COORD_W+2)'(LEAD);
    localparam logic signed [COORD_W+1:0] MAX_S  = (COORD_W+2)'(MAX_VAL);

    logic signed [COORD_W+1:0] base_ext;
    logic signed [COORD_W+1:0] idx_ext;
    logic signed [COORD_W+1:0] sum;

    assign base_ext = {base[COORD_W], base};
    assign idx_ext  = {{(COORD_W+2-IDX_W){1'b0}}, idx};
    assign sum      = base_ext + idx_ext - LEAD_S;

    always_comb begin
        if (sum[COORD_W+1]) begin
            coord = '0;                       // left/above the frame
        end else if (sum > MAX_S) begin
            coord = MAX_S[COORD_W-1:0];       // right/below the frame
        end else begin
            coord = sum[COORD_W-1:0];
        end
    end

endmodule

// File: rtl/ref_window_loader.sv
// Loads the (NUM_PIXEL+7)^2 integer-pel reference window around a block and
// streams it row by row to the subpixel interpolator.
// Ports:
//   clock, reset           : clock, asynchronous active-high reset
//   start, blk_x, blk_y    : load request and signed block origin
//   busy, done             : operation in progress / one-cycle completion
//   mem_rd_req/gnt/x/y     : pixel read request channel (one pixel each)
//   mem_rd_valid/data      : in-order read responses
//   win_valid/ready        : row handshake towards the interpolator
//   win_data               : row pixels, column c at [c*PIX_W +: PIX_W]
//   win_row, win_last      : row index and last-row flag
// Each row is fetched into a row buffer (requests and responses overlap),
// then presented on win_data until accepted, then the next row is fetched.
module ref_window_loader
    import ref_window_pkg::*;
#(
    parameter int NUM_PIXEL = 8,
    parameter int PIX_W     = 8,
    parameter int COORD_W   = 12,
    parameter int FRAME_W   = 1920,
    parameter int FRAME_H   = 1080,
    localparam int W        = win_edge(NUM_PIXEL)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic signed [COORD_W:0] blk_x,
    input  logic signed [COORD_W:0] blk_y,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_rd_req,
    input  logic                   mem_rd_gnt,
    output logic [COORD_W-1:0]     mem_rd_x,
    output logic [COORD_W-1:0]     mem_rd_y,
    input  logic                   mem_rd_valid,
    input  logic [PIX_W-1:0]       mem_rd_data,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic [W*PIX_W-1:0]     win_data,
    output logic [3:0]             win_row,
    output logic                   win_last
);

    localparam int                CNT_W    = $clog2(W + 1);
    localparam logic [CNT_W-1:0]  W_CNT    = CNT_W'(W);
    localparam logic [CNT_W-1:0]  LAST_COL = CNT_W'(W - 1);
    localparam logic [3:0]        LAST_ROW = 4'(W - 1);

    state_t                 state_reg, state_next;
    logic signed [COORD_W:0] blk_x_reg, blk_y_reg;
    logic [CNT_W-1:0]       rq_reg;     // next column to request
    logic [CNT_W-1:0]       rs_reg;     // next column to receive
    logic [3:0]             row_reg;
    logic                   win_valid_reg;

    logic                   req_fire;
    logic                   rsp_take;
    logic                   rsp_last;
    logic [COORD_W-1:0]     clamp_x, clamp_y;

    assign mem_rd_req = (state_reg == FETCH) && (rq_reg < W_CNT);
    assign req_fire   = mem_rd_req && mem_rd_gnt;
    // Responses outside FETCH or beyond the last column are strays.
    assign rsp_take   = (state_reg == FETCH) && mem_rd_valid && (rs_reg < W_CNT);
    assign rsp_last   = rsp_take && (rs_reg == LAST_COL);

    coord_clamp #(
        .COORD_W (COORD_W),
        .IDX_W   (CNT_W),
        .LEAD    (KERNEL_LEAD),
        .MAX_VAL (clamp_max(FRAME_W))
    ) u_clamp_x (
        .base  (blk_x_reg),
        .idx   (rq_reg),
        .coord (clamp_x)
    );

    coord_clamp #(
        .COORD_W (COORD_W),
        .IDX_W   (4),
        .LEAD    (KERNEL_LEAD),
        .MAX_VAL (clamp_max(FRAME_H))
    ) u_clamp_y (
        .base  (blk_y_reg),
        .idx   (row_reg),
        .coord (clamp_y)
    );

    // Address is a pure function of registered state, so it stays put
    // while a request waits for grant; it reads as zero when idle.
    assign mem_rd_x = mem_rd_req ? clamp_x : '0;
    assign mem_rd_y = mem_rd_req ? clamp_y : '0;

    // Next-state and status decode.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                busy = 1'b1;
                // Move on as the last pixel lands so win_valid rises the
                // cycle right after the final response.
                if (rsp_last) state_next = SEND;
            end
            SEND: begin
                busy = 1'b1;
                if (win_ready) state_next = (row_reg == LAST_ROW) ? DONE : FETCH;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            blk_x_reg     <= '0;
            blk_y_reg     <= '0;
            rq_reg        <= '0;
            rs_reg        <= '0;
            row_reg       <= '0;
            win_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        blk_x_reg <= blk_x;
                        blk_y_reg <= blk_y;
                        rq_reg    <= '0;
                        rs_reg    <= '0;
                        row_reg   <= '0;
                    end
                end
                FETCH: begin
                    if (req_fire) rq_reg <= rq_reg + 1'b1;
                    if (rsp_take) rs_reg <= rs_reg + 1'b1;
                    if (rsp_last) win_valid_reg <= 1'b1;
                end
                SEND: begin
                    if (win_ready) begin
                        win_valid_reg <= 1'b0;
                        if (row_reg != LAST_ROW) begin
                            row_reg <= row_reg + 1'b1;
                            rq_reg  <= '0;
                            rs_reg  <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Row buffer: one register per column, written in response order.
    // It feeds win_data directly; it only changes in FETCH, so it is
    // stable for the whole SEND phase.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_col
            logic [PIX_W-1:0] pix_reg;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    pix_reg <= '0;
                end else if (rsp_take && (rs_reg == CNT_W'(gi))) begin
                    pix_reg <= mem_rd_data;
                end
            end
            assign win_data[gi*PIX_W +: PIX_W] = pix_reg;
        end
    endgenerate

    assign win_valid = win_valid_reg;
    assign win_row   = row_reg;
    assign win_last  = win_valid_reg && (row_reg == LAST_ROW);

endmodule

// File: tb/tb_ref_window_loader.sv
`timescale 1ns/1ps
module tb_ref_window_loader;

    localparam int NP = 8, PW = 8, CW = 12, FW = 1920, FH = 1080;
    localparam int W  = NP + 7;
    localparam int WB = W * PW;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic signed [CW:0]   blk_x = '0, blk_y = '0;
    logic                 busy, done, mem_rd_req, win_valid, win_last;
    logic                 mem_rd_gnt = 1'b0, mem_rd_valid = 1'b0, win_ready = 1'b0;
    logic [CW-1:0]        mem_rd_x, mem_rd_y;
    logic [PW-1:0]        mem_rd_data = '0;
    logic [WB-1:0]        win_data;
    logic [3:0]           win_row;

    ref_window_loader #(
        .NUM_PIXEL(NP), .PIX_W(PW), .COORD_W(CW), .FRAME_W(FW), .FRAME_H(FH)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .blk_x(blk_x), .blk_y(blk_y),
        .busy(busy), .done(done), .mem_rd_req(mem_rd_req), .mem_rd_gnt(mem_rd_gnt),
        .mem_rd_x(mem_rd_x), .mem_rd_y(mem_rd_y), .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data), .win_valid(win_valid), .win_ready(win_ready),
        .win_data(win_data), .win_row(win_row), .win_last(win_last)
    );

    always #5 clock = ~clock;

    int n_checks = 0, n_pass = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- reference frame and memory model ----------------
    int gnt_pct = 100, lat_max = 1, pix_mode = 0;
    bit stray_en = 1'b0;
    int max_x, max_y, n_req;

    typedef struct { int due; logic [7:0] data; } rsp_t;
    rsp_t rsp_q[$];
    int   last_due = 0;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic logic [7:0] pix(input int x, input int y);
        case (pix_mode)
            0:       return 8'((x + y) & 255);
            1:       return 8'((x * 3 + y * 7) & 255);
            default: return 8'(((x ^ y) + 90) & 255);
        endcase
    endfunction

    // Expected row r of the window for block (bx,by): edge-replicated frame.
    function automatic logic [WB-1:0] model_row(input int bx, input int by, input int r);
        logic [WB-1:0] v;
        int y;
        y = clampi(by - 3 + r, 0, FH - 1);
        for (int c = 0; c < W; c++) v[c*PW +: PW] = pix(clampi(bx - 3 + c, 0, FW - 1), y);
        return v;
    endfunction

    // In-order memory with random grant and random latency (>=1).
    always @(negedge clock) begin : mem_model
        rsp_t e;
        int   lat;
        int   due;
        if (reset) begin
            rsp_q.delete();
            last_due     = 0;
            mem_rd_valid = 1'b0;
            mem_rd_gnt   = 1'b0;
            mem_rd_data  = '0;
        end else begin
            mem_rd_valid = 1'b0;
            mem_rd_data  = '0;
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = rsp_q[0].data;
                void'(rsp_q.pop_front());
            end else if (stray_en) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = 8'hA5;
            end
            mem_rd_gnt = (int'($urandom_range(99)) < gnt_pct);
            if (mem_rd_req && mem_rd_gnt) begin
                lat = int'($urandom_range(lat_max, 1));
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                e.due  = due;
                e.data = pix(int'(mem_rd_x), int'(mem_rd_y));
                rsp_q.push_back(e);
                n_req++;
                if (int'(mem_rd_x) > max_x) max_x = int'(mem_rd_x);
                if (int'(mem_rd_y) > max_y) max_y = int'(mem_rd_y);
            end
        end
    end

    // ---------------- window driver / capture ----------------
    logic [WB-1:0] cap_data [W];
    int            cap_row  [W];
    bit            cap_last [W];
    int  cap_n, done_cnt, unstable, first_req_off, first_valid_off;
    bit  timed_out, done_busy_bad;

    task automatic run_window(input int bx, input int by, input int gap,
                              input int abort_row, input int misuse_at);
        int s, k, gap_cnt, abort_cnt, post;
        bit prev_hold, seen_done;
        logic [WB-1:0] h_data;
        logic [3:0]    h_row;
        logic          h_last;
        gap_cnt = 0; abort_cnt = 0; post = 0; prev_hold = 0; seen_done = 0;
        h_data = '0; h_row = '0; h_last = 1'b0;
        for (int i = 0; i < W; i++) begin
            cap_data[i] = 'x; cap_row[i] = -1; cap_last[i] = 1'b0;
        end
        cap_n = 0; done_cnt = 0; unstable = 0; first_req_off = -1; first_valid_off = -1;
        timed_out = 0; done_busy_bad = 0; max_x = 0; max_y = 0; n_req = 0;
        @(negedge clock);
        blk_x = (CW+1)'(bx); blk_y = (CW+1)'(by); start = 1'b1;
        s = cyc;
        while (1) begin
            @(negedge clock);
            start = 1'b0;
            k = cyc - s;
            blk_x = (CW+1)'($urandom);
            blk_y = (CW+1)'($urandom);
            if (k == misuse_at) start = 1'b1;
            if (k > 6000) begin timed_out = 1; break; end
            if (mem_rd_req && first_req_off < 0) first_req_off = k;
            if (done) begin done_cnt++; seen_done = 1; end
            if (seen_done) begin
                if (busy) done_busy_bad = 1;
                post++;
                if (post == 3) break;
            end
            if (win_valid) begin
                if (first_valid_off < 0) first_valid_off = k;
                if (prev_hold && (win_data !== h_data || win_row !== h_row || win_last !== h_last))
                    unstable++;
                if (gap_cnt < gap) begin
                    win_ready = 1'b0; gap_cnt++; prev_hold = 1;
                    h_data = win_data; h_row = win_row; h_last = win_last;
                end else begin
                    win_ready = 1'b1; gap_cnt = 0; prev_hold = 0;
                    if (cap_n < W) begin
                        cap_data[cap_n] = win_data; cap_row[cap_n] = int'(win_row);
                        cap_last[cap_n] = win_last;
                    end
                    cap_n++;
                end
            end else begin
                if (prev_hold) unstable++;
                win_ready = 1'b0; prev_hold = 0;
            end
            if (abort_row >= 0 && cap_n == abort_row && mem_rd_req) begin
                abort_cnt++;
                if (abort_cnt == 4) break;
            end
        end
        win_ready = 1'b0;
        $display("window blk=(%0d,%0d) gap=%0d rows=%0d requests=%0d cycles=%0d",
                 bx, by, gap, cap_n, n_req, k);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge clock);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (mem_rd_req !== 1'b0) $display("FAIL reset_req: got %b want 0", mem_rd_req); else n_pass++;
        n_checks++; if (win_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", win_valid); else n_pass++;
        n_checks++; if (win_last !== 1'b0) $display("FAIL reset_last: got %b want 0", win_last); else n_pass++;
        n_checks++; if (win_data !== '0) $display("FAIL reset_data: got %h want 0", win_data); else n_pass++;
        n_checks++; if (win_row !== 4'd0) $display("FAIL reset_row: got %0d want 0", win_row); else n_pass++;
        n_checks++; if (mem_rd_x !== '0 || mem_rd_y !== '0)
            $display("FAIL reset_addr: got (%0d,%0d) want (0,0)", mem_rd_x, mem_rd_y); else n_pass++;
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_interior();
        logic [WB-1:0] exp;
        pix_mode = 0; gnt_pct = 100; lat_max = 1;
        run_window(100, 50, 0, -1, -1);
        n_checks++; if (timed_out !== 1'b0 || cap_n != W)
            $display("FAIL interior_rows: got %0d rows timeout=%0d want %0d", cap_n, timed_out, W); else n_pass++;
        n_checks++; if (first_req_off != 1) $display("FAIL interior_req_lat: got %0d want 1", first_req_off); else n_pass++;
        n_checks++; if (first_valid_off != W + 2)
            $display("FAIL interior_valid_lat: got %0d want %0d", first_valid_off, W + 2); else n_pass++;
        n_checks++; if (cap_data[0][7:0] !== 8'd144) $display("FAIL interior_r0c0: got %0d want 144", cap_data[0][7:0]); else n_pass++;
        n_checks++; if (cap_data[14][14*PW +: PW] !== 8'd172)
            $display("FAIL interior_r14c14: got %0d want 172", cap_data[14][14*PW +: PW]); else n_pass++;
        for (int r = 0; r < W; r++) begin
            exp = model_row(100, 50, r);
            n_checks++; if (cap_data[r] !== exp) $display("FAIL interior_row%0d: got %h want %h", r, cap_data[r], exp); else n_pass++;
            n_checks++; if (cap_row[r] != r || cap_last[r] !== (r == W - 1))
                $display("FAIL interior_tag%0d: got row %0d last %b want row %0d last %b", r, cap_row[r], cap_last[r], r, (r == W - 1));
            else n_pass++;
        end
        n_checks++; if (done_cnt != 1 || done_busy_bad)
            $display("FAIL interior_done: got %0d pulses busy_bad=%0d want 1 pulse", done_cnt, done_busy_bad); else n_pass++;
    endtask

    task automatic test_corner();
        logic [WB-1:0] exp;
        pix_mode = 0;
        run_window(0, 0, 0, -1, -1);
        n_checks++; if (cap_n != W) $display("FAIL corner_rows: got %0d want %0d", cap_n, W); else n_pass++;
        n_checks++; if (cap_data[0][3*PW +: PW] !== 8'd0) $display("FAIL corner_r0c3: got %0d want 0", cap_data[0][3*PW +: PW]); else n_pass++;
        n_checks++; if (cap_data[3][4*PW +: PW] !== 8'd1) $display("FAIL corner_r3c4: got %0d want 1", cap_data[3][4*PW +: PW]); else n_pass++;
        for (int r = 0; r < W; r++) begin
            exp = model_row(0, 0, r);
            n_checks++; if (cap_data[r] !== exp) $display("FAIL corner_row%0d: got %h want %h", r, cap_data[r], exp); else n_pass++;
        end
    endtask

    task automatic test_bottom_right();
        logic [WB-1:0] exp;
        pix_mode = 1;
        run_window(1916, 1076, 0, -1, -1);
        n_checks++; if (max_x != FW - 1 || max_y != FH - 1)
            $display("FAIL br_max_addr: got (%0d,%0d) want (%0d,%0d)", max_x, max_y, FW - 1, FH - 1); else n_pass++;
        for (int r = 0; r < W; r++) begin
            exp = model_row(1916, 1076, r);
            n_checks++; if (cap_data[r] !== exp) $display("FAIL br_row%0d: got %h want %h", r, cap_data[r], exp); else n_pass++;
        end
    endtask

    task automatic test_negative();
        logic [WB-1:0] flat;
        pix_mode = 2;
        for (int c = 0; c < W; c++) flat[c*PW +: PW] = 8'h5A;
        run_window(-20, -20, 0, -1, -1);
        n_checks++; if (max_x != 0 || max_y != 0 || n_req != W * W)
            $display("FAIL neg_addr: got max (%0d,%0d) reqs %0d want (0,0) %0d", max_x, max_y, n_req, W * W); else n_pass++;
        for (int r = 0; r < W; r++) begin
            n_checks++; if (cap_data[r] !== flat) $display("FAIL neg_row%0d: got %h want %h", r, cap_data[r], flat); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [WB-1:0] exp;
        pix_mode = 1;
        run_window(333, 777, 5, -1, -1);
        n_checks++; if (unstable != 0) $display("FAIL bp_stable: got %0d changes want 0", unstable); else n_pass++;
        n_checks++; if (cap_n != W) $display("FAIL bp_rows: got %0d want %0d", cap_n, W); else n_pass++;
        for (int r = 0; r < W; r++) begin
            exp = model_row(333, 777, r);
            n_checks++; if (cap_data[r] !== exp) $display("FAIL bp_row%0d: got %h want %h", r, cap_data[r], exp); else n_pass++;
        end
    endtask

    task automatic test_jitter();
        logic [WB-1:0] exp;
        pix_mode = 0; gnt_pct = 50; lat_max = 6;
        run_window(100, 50, 0, -1, -1);
        gnt_pct = 100; lat_max = 1;
        n_checks++; if (timed_out !== 1'b0 || cap_n != W)
            $display("FAIL jitter_rows: got %0d timeout=%0d want %0d", cap_n, timed_out, W); else n_pass++;
        for (int r = 0; r < W; r++) begin
            exp = model_row(100, 50, r);
            n_checks++; if (cap_data[r] !== exp) $display("FAIL jitter_row%0d: got %h want %h", r, cap_data[r], exp); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [WB-1:0] exp;
        pix_mode = 1;
        run_window(500, 400, 0, 7, -1);
        reset = 1'b1;
        #1;
        n_checks++; if ({busy, done, mem_rd_req, win_valid, win_last} !== 5'b0)
            $display("FAIL midrst_ctrl: got %b want 00000", {busy, done, mem_rd_req, win_valid, win_last}); else n_pass++;
        n_checks++; if (win_data !== '0) $display("FAIL midrst_data: got %h want 0", win_data); else n_pass++;
        n_checks++; if (win_row !== 4'd0) $display("FAIL midrst_row: got %0d want 0", win_row); else n_pass++;
        n_checks++; if (mem_rd_x !== '0 || mem_rd_y !== '0)
            $display("FAIL midrst_addr: got (%0d,%0d) want (0,0)", mem_rd_x, mem_rd_y); else n_pass++;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        run_window(500, 400, 0, -1, -1);
        n_checks++; if (cap_n != W || done_cnt != 1)
            $display("FAIL midrst_rerun: got %0d rows %0d done want %0d rows 1 done", cap_n, done_cnt, W); else n_pass++;
        for (int r = 0; r < W; r++) begin
            exp = model_row(500, 400, r);
            n_checks++; if (cap_data[r] !== exp) $display("FAIL midrst_row%0d: got %h want %h", r, cap_data[r], exp); else n_pass++;
        end
    endtask

    task automatic test_start_misuse();
        logic [WB-1:0] exp;
        pix_mode = 1;
        run_window(64, 900, 3, -1, 40);
        n_checks++; if (cap_n != W || done_cnt != 1)
            $display("FAIL misuse_count: got %0d rows %0d done want %0d rows 1 done", cap_n, done_cnt, W); else n_pass++;
        for (int r = 0; r < W; r++) begin
            exp = model_row(64, 900, r);
            n_checks++; if (cap_data[r] !== exp) $display("FAIL misuse_row%0d: got %h want %h", r, cap_data[r], exp); else n_pass++;
        end
    endtask

    task automatic test_stray();
        logic [WB-1:0] exp;
        exp = model_row(64, 900, W - 1);   // buffer still holds last row of last window
        stray_en = 1'b1;
        repeat (5) @(negedge clock);
        stray_en = 1'b0;
        @(negedge clock);
        n_checks++; if (win_data !== exp) $display("FAIL stray_idle: got %h want %h", win_data, exp); else n_pass++;
        n_checks++; if (busy !== 1'b0 || mem_rd_req !== 1'b0)
            $display("FAIL stray_state: got busy %b req %b want 0 0", busy, mem_rd_req); else n_pass++;
    endtask

    task automatic test_random();
        logic [WB-1:0] exp;
        int bx, by, gap;
        pix_mode = 1;
        for (int it = 0; it < 3; it++) begin
            bx = int'($urandom_range(1960)) - 30;
            by = int'($urandom_range(1120)) - 30;
            gap = int'($urandom_range(3));
            gnt_pct = int'($urandom_range(100, 40));
            lat_max = int'($urandom_range(6, 1));
            run_window(bx, by, gap, -1, -1);
            n_checks++; if (cap_n != W || done_cnt != 1 || unstable != 0)
                $display("FAIL rand%0d_flow: got rows %0d done %0d unstable %0d want %0d 1 0", it, cap_n, done_cnt, unstable, W);
            else n_pass++;
            for (int r = 0; r < W; r++) begin
                exp = model_row(bx, by, r);
                n_checks++; if (cap_data[r] !== exp)
                    $display("FAIL rand%0d_row%0d: got %h want %h", it, r, cap_data[r], exp); else n_pass++;
            end
        end
        gnt_pct = 100; lat_max = 1;
    endtask

    initial begin
        test_reset();
        test_interior();
        test_corner();
        test_bottom_right();
        test_negative();
        test_backpressure();
        test_jitter();
        test_reset_mid();
        test_start_misuse();
        test_stray();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ref_window_loader.md
Name: ref_window_loader

Overview:
- Feeds the subpixel interpolation datapath at its input end.
- On `start`, fetches the (NUM_PIXEL+7)x(NUM_PIXEL+7) integer-pixel reference window around a block position, one pixel per memory read.
- Clamps out-of-frame coordinates to the frame edge, giving HEVC edge replication.
- Streams the window one row per transfer to the interpolator over a valid/ready handshake.

Parameters:
- NUM_PIXEL, 8, block edge in pixels; window edge W = NUM_PIXEL+7.
- PIX_W, 8, bits per pixel.
- COORD_W, 12, unsigned frame coordinate width.
- FRAME_W, 1920, frame width in pixels.
- FRAME_H, 1080, frame height in pixels.

Ports:
- clock, in, 1, clock.
- reset, in, 1, async active-high reset.
- start, in, 1, one-cycle request to load a window; sampled only in IDLE.
- blk_x, in, COORD_W+1, signed two's-complement x of block top-left, integer-pel.
- blk_y, in, COORD_W+1, signed y of block top-left.
- busy, out, 1, high from the cycle after accepted start until DONE exits.
- done, out, 1, one-cycle pulse after last row handshake.
- mem_rd_req, out, 1, read request valid.
- mem_rd_gnt, in, 1, request accepted when req&gnt.
- mem_rd_x, out, COORD_W, clamped pixel x.
- mem_rd_y, out, COORD_W, clamped pixel y.
- mem_rd_valid, in, 1, read data valid; responses in request order, latency >=1, variable.
- mem_rd_data, in, PIX_W, read pixel.
- win_valid, out, 1, row data valid.
- win_ready, in, 1, interpolator accepts row.
- win_data, out, W*PIX_W, row pixels; column c at [c*PIX_W +: PIX_W], column 0 leftmost.
- win_row, out, 4, row index 0..W-1.
- win_last, out, 1, high with row W-1.

Behaviour:
- Reset (async): state IDLE, all counters 0, row buffer 0. busy, done, mem_rd_req, win_valid and win_last are 0. win_data, win_row, mem_rd_x and mem_rd_y are 0.
- Accept: in IDLE, start=1 latches blk_x/blk_y, clears counters, and moves to FETCH. start in any other state is ignored.
- FETCH, requests:
  - Request counter rq (0..W) issues column rq of current row r.
  - Coordinates: x = blk_x-3+rq, y = blk_y-3+r, each clamped to [0, FRAME_W-1] / [0, FRAME_H-1].
  - mem_rd_req=1 while rq<W; rq increments on req&gnt.
  - Address is stable while req=1 and gnt=0.
- FETCH, responses:
  - Response counter rs (0..W); each mem_rd_valid writes mem_rd_data into row buffer column rs, then rs++.
  - At most W outstanding; the request and response sides run concurrently.
- FETCH -> SEND the cycle after rs reaches W; win_valid=1 registered in that same transition.
- SEND:
  - Hold win_valid, win_data, win_row and win_last stable until win_ready.
  - On handshake with r<W-1: r++, rq=rs=0, back to FETCH (win_valid drops next cycle).
  - On handshake with r=W-1: go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Stray responses: mem_rd_valid outside FETCH, or with rs=W, is ignored (no buffer write).
- Reset mid-operation: immediate return to IDLE, all outputs to reset values. The memory side shares the same reset, so no responses remain in flight.
- Arithmetic: sign-extend to COORD_W+2 before adding the offset; values below 0 clamp to 0, values above max clamp to max. No wrap-around.
- Latency (gnt tied 1, 1-cycle read latency, start at cycle 0):
  - req at cycles 1..W, data at cycles 2..W+1, win_valid at cycle W+2 for row 0.
  - Each row costs W+2 cycles plus backpressure.

Decomposition:
- Package ref_window_pkg: W derived constant, state enum (IDLE, FETCH, SEND, DONE), clamp-bound helper constants.
- Sub-module coord_clamp: combinational signed-offset-and-clamp, one instance per axis.

Test Plan:
- Interior: blk=(100,50), memory returns (x+y)&0xFF, gnt=1, latency 1 -> 15 rows. Row 0 col 0=144, row 14 col 14=172. win_last only on row 14. done pulse once.
- Top-left corner: blk=(0,0) -> rows 0..3 identical to row y=0. Columns 0..3 equal pixel x=0 (value 0 at row 0). Row 3 col 4 = 1.
- Bottom-right beyond frame: blk=(1916,1076) -> requested x never exceeds 1919, y never exceeds 1079. Last columns/rows replicated.
- Negative: blk=(-20,-20) -> every request is (0,0); all 225 pixels equal the (0,0) value.
- Backpressure and jitter:
  - win_ready low 5 cycles per row -> row data stable while valid.
  - gnt random 50% and latency 1..6 -> identical data to the interior case.
- Reset and start misuse:
  - reset asserted mid-row 7 -> outputs zero that cycle; a fresh start then completes correctly.
  - start pulsed while busy -> ignored, no change in outputs.
